// File: rtl/async_pkg.sv
// Shared dual-rail link types, encoding helpers and the token-source FSM states.
package async_pkg;

    localparam int RAIL_NUM = 2;

    typedef enum logic {
        ENC_TP = 1'b0,
        ENC_FP = 1'b1
    } enc_e;

    typedef logic [RAIL_NUM-1:0] dr_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RTZ      = 3'd3,
        ST_WAIT_RTZ = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Rail 1 carries logic 1, rail 0 carries logic 0.
    function automatic dr_t dr_encode(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    function automatic dr_t dr_toggle(input dr_t d, input logic b);
        return d ^ dr_encode(b);
    endfunction

endpackage

// File: rtl/recur_tp_src_ack_sync.sv
// Generic multi-flop synchroniser for a single asynchronous control bit.
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Synchroniser shift chain, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/recur_tp_src.sv
// Clocked K-th order additive recurrence source driving a dual-rail
// asynchronous link in two-phase or four-phase signalling.
module recur_tp_src
    import async_pkg::*;
#(
    parameter int                     WIDTH       = 32,
    parameter int                     ORDER       = 2,
    parameter logic [ORDER*WIDTH-1:0] SEED        = (ORDER*WIDTH)'(1) << (WIDTH*(ORDER-1)),
    parameter string                  ENC         = "TP",
    parameter int                     N_TERMS     = 0,
    parameter int                     SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           ack_i,
    output logic [WIDTH-1:0][RAIL_NUM-1:0] out,
    output logic [RAIL_NUM-1:0]            c_out,
    output logic                           busy,
    output logic                           done
);

    localparam enc_e        ENC_SEL = (ENC == "FP") ? ENC_FP : ENC_TP;
    localparam bit          IS_FP   = (ENC_SEL == ENC_FP);
    localparam int          SW      = WIDTH + 2;
    localparam logic [31:0] N_LIM   = 32'(N_TERMS);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_hist [ORDER];
    logic [ORDER-1:0] r_hcar;
    logic [31:0]      r_cnt;
    logic             r_phase;
    logic             w_ack_s;
    logic             w_ack_hit;
    logic [SW-1:0]    w_sum;
    logic [31:0]      w_cnt_chk;
    logic             w_take;
    logic             w_check;
    logic             w_go_done;
    logic             w_go_pause;
    logic             w_restart;

    ack_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .i_d(ack_i),
        .o_q(w_ack_s)
    );

    // Two-phase acks are edges relative to the expected phase; four-phase acks are levels.
    assign w_ack_hit = IS_FP ? w_ack_s : (w_ack_s ^ r_phase);

    // Next recurrence term over the whole history window, with two guard bits
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < ORDER; i++) begin
            w_sum = w_sum + SW'(r_hist[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_check     = 1'b0;
        w_cnt_chk   = r_cnt;
        w_go_done   = 1'b0;
        w_go_pause  = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_ISSUE;
                else       w_state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (w_ack_hit) begin
                    w_take = 1'b1;
                    if (IS_FP) begin
                        w_state_nxt = ST_RTZ;
                    end else begin
                        // The count increments on this same edge, so test its next value.
                        w_check   = 1'b1;
                        w_cnt_chk = r_cnt + 32'd1;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_RTZ: begin
                w_state_nxt = ST_WAIT_RTZ;
            end
            ST_WAIT_RTZ: begin
                if (!w_ack_s) w_check     = 1'b1;
                else          w_state_nxt = ST_WAIT_RTZ;
            end
            ST_PAUSE: begin
                if (start) w_state_nxt = ST_ISSUE;
                else       w_state_nxt = ST_PAUSE;
            end
            ST_DONE: begin
                if (!start) begin
                    w_state_nxt = ST_IDLE;
                    w_restart   = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_check) begin
            if ((N_TERMS != 0) && (w_cnt_chk == N_LIM)) begin
                w_state_nxt = ST_DONE;
                w_go_done   = 1'b1;
            end else if (!start) begin
                w_state_nxt = ST_PAUSE;
                w_go_pause  = 1'b1;
            end else begin
                w_state_nxt = ST_ISSUE;
            end
        end else begin
            w_go_done  = 1'b0;
            w_go_pause = 1'b0;
        end
    end

    // Token rails, status flags, history window, phase and term count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            c_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_hcar  <= '0;
            for (int i = 0; i < ORDER; i++) begin
                r_hist[i] <= SEED[i*WIDTH +: WIDTH];
            end
        end else begin
            if (r_state == ST_ISSUE) begin
                busy <= 1'b1;
                for (int b = 0; b < WIDTH; b++) begin
                    out[b] <= IS_FP ? dr_encode(r_hist[0][b]) : dr_toggle(out[b], r_hist[0][b]);
                end
                c_out <= IS_FP ? dr_encode(r_hcar[0]) : dr_toggle(c_out, r_hcar[0]);
            end else if (r_state == ST_RTZ) begin
                out   <= '0;
                c_out <= '0;
            end
            if (w_take) begin
                r_cnt   <= r_cnt + 32'd1;
                r_phase <= IS_FP ? r_phase : ~r_phase;
                for (int i = 0; i < ORDER-1; i++) begin
                    r_hist[i] <= r_hist[i+1];
                end
                r_hist[ORDER-1] <= w_sum[WIDTH-1:0];
                r_hcar          <= {(|w_sum[SW-1:WIDTH]), r_hcar[ORDER-1:1]};
            end
            if (w_go_done) begin
                done <= 1'b1;
                busy <= 1'b0;
            end else if (w_go_pause) begin
                busy <= 1'b0;
            end
            if (w_restart) begin
                done   <= 1'b0;
                r_cnt  <= '0;
                r_hcar <= '0;
                for (int i = 0; i < ORDER; i++) begin
                    r_hist[i] <= SEED[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_recur_tp_src.sv
// Directed bench for recur_tp_src: four-phase Fibonacci, two-phase tribonacci,
// bounded run with pause/restart, and asynchronous reset mid-handshake.
module tb_recur_tp_src;

    logic clk;
    logic rst;
    logic [2:0] st;
    logic [2:0] ak;
    logic [2:0] bz;
    logic [2:0] dn;
    logic [7:0][1:0] o0, o1, o2;
    logic [1:0] c0, c1, c2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0][1:0] tp_prev  = '0;
    logic [1:0]      tp_prevc = '0;

    typedef struct {
        int         dly;
        logic [7:0] v;
        logic       c;
    } vec_t;

    vec_t fib  [16];
    vec_t trib [9];

    recur_tp_src #(.WIDTH(8), .ORDER(2), .SEED(16'h0100), .ENC("FP"), .N_TERMS(0), .SYNC_STAGES(2)) u_fp (
        .clk(clk), .rst(rst), .start(st[0]), .ack_i(ak[0]),
        .out(o0), .c_out(c0), .busy(bz[0]), .done(dn[0]));

    recur_tp_src #(.WIDTH(8), .ORDER(3), .SEED(24'h010000), .ENC("TP"), .N_TERMS(0), .SYNC_STAGES(2)) u_tp (
        .clk(clk), .rst(rst), .start(st[1]), .ack_i(ak[1]),
        .out(o1), .c_out(c1), .busy(bz[1]), .done(dn[1]));

    recur_tp_src #(.WIDTH(8), .ORDER(2), .SEED(16'h0100), .ENC("FP"), .N_TERMS(5), .SYNC_STAGES(2)) u_nt (
        .clk(clk), .rst(rst), .start(st[2]), .ack_i(ak[2]),
        .out(o2), .c_out(c2), .busy(bz[2]), .done(dn[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0][1:0] go(input int k);
        case (k)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    function automatic logic [1:0] gc(input int k);
        case (k)
            0:       return c0;
            1:       return c1;
            default: return c2;
        endcase
    endfunction

    function automatic bit fp_valid(input int k);
        logic [7:0][1:0] o;
        logic [1:0]      c;
        bit              ok;
        o  = go(k);
        c  = gc(k);
        ok = (c == 2'b01) || (c == 2'b10);
        for (int b = 0; b < 8; b++) begin
            if (!((o[b] == 2'b01) || (o[b] == 2'b10))) ok = 1'b0;
        end
        return ok;
    endfunction

    // Four-phase consumer: capture codeword, raise ack, wait for spacer, drop ack.
    task automatic fp_recv(input int k, input int dly, input bit drop,
                           output logic [7:0] v, output logic c, output bit ok);
        int              n;
        logic [7:0][1:0] o;
        logic [1:0]      tc;
        ok = 1'b1;
        n  = 0;
        while (!fp_valid(k) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) ok = 1'b0;
        o  = go(k);
        tc = gc(k);
        for (int b = 0; b < 8; b++) v[b] = o[b][1];
        c = tc[1];
        check($sformatf("busy_tok%0d", k), 32'(bz[k]), 32'd1);
        if (drop) st[k] = 1'b0;
        repeat (dly) @(negedge clk);
        ak[k] = 1'b1;
        n = 0;
        while (!(go(k) == '0 && gc(k) == '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) ok = 1'b0;
        repeat (dly) @(negedge clk);
        ak[k] = 1'b0;
    endtask

    // Two-phase consumer on instance 1: decode the rail transitions, then toggle ack.
    task automatic tp_recv(input int dly, output logic [7:0] v, output logic c,
                           output bit onehot, output bit ok);
        int              n;
        logic [7:0][1:0] d;
        logic [1:0]      dc;
        ok = 1'b1;
        n  = 0;
        while (o1 == tp_prev && c1 == tp_prevc && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) ok = 1'b0;
        d      = o1 ^ tp_prev;
        dc     = c1 ^ tp_prevc;
        onehot = (dc == 2'b01) || (dc == 2'b10);
        for (int b = 0; b < 8; b++) begin
            if (!((d[b] == 2'b01) || (d[b] == 2'b10))) onehot = 1'b0;
            v[b] = d[b][1];
        end
        c        = dc[1];
        tp_prev  = o1;
        tp_prevc = c1;
        repeat (dly) @(negedge clk);
        check("tp_hold", 32'(o1), 32'(tp_prev));
        ak[1] = ~ak[1];
    endtask

    initial begin
        int         fv [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
        int         tv [9]  = '{0, 0, 1, 1, 2, 4, 7, 13, 24};
        int         nv [5]  = '{0, 1, 1, 2, 3};
        logic [7:0] v;
        logic       c;
        bit         ok;
        bit         oh;
        int         n;

        for (int i = 0; i < 16; i++) fib[i] = '{1 + (i % 3), 8'(fv[i]), (i >= 14)};
        for (int i = 0; i < 9; i++)  trib[i] = '{4 + (i % 2), 8'(tv[i]), 1'b0};

        rst = 1'b1;
        st  = 3'b000;
        ak  = 3'b000;
        @(negedge clk);
        check("rst_out", 32'(o0), 32'd0);
        check("rst_cout", 32'(c0), 32'd0);
        check("rst_busy", 32'(bz), 32'd0);
        check("rst_done", 32'(dn), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Four-phase Fibonacci with wrap and carry on tokens 14 and 15
        st[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fp_recv(0, fib[i].dly, 1'b0, v, c, ok);
            check($sformatf("fib_ok[%0d]", i), 32'(ok), 32'd1);
            check($sformatf("fib_val[%0d]", i), 32'(v), 32'(fib[i].v));
            check($sformatf("fib_c[%0d]", i), 32'(c), 32'(fib[i].c));
        end

        // Two-phase tribonacci
        st[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tp_recv(trib[i].dly, v, c, oh, ok);
            check($sformatf("tp_ok[%0d]", i), 32'(ok), 32'd1);
            check($sformatf("tp_onehot[%0d]", i), 32'(oh), 32'd1);
            check($sformatf("tp_val[%0d]", i), 32'(v), 32'(trib[i].v));
            check($sformatf("tp_c[%0d]", i), 32'(c), 32'(trib[i].c));
        end

        // Bounded run: start dropped during token 3, then done and restart
        st[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fp_recv(2, 3, (i == 3), v, c, ok);
            check($sformatf("nt_ok[%0d]", i), 32'(ok), 32'd1);
            check($sformatf("nt_val[%0d]", i), 32'(v), 32'(nv[i]));
            if (i == 3) begin
                repeat (10) @(negedge clk);
                check("pause_busy", 32'(bz[2]), 32'd0);
                check("pause_out", 32'(o2), 32'd0);
                check("pause_done", 32'(dn[2]), 32'd0);
                repeat (10) @(negedge clk);
                check("pause_hold", 32'(o2), 32'd0);
                st[2] = 1'b1;
            end
        end
        repeat (10) @(negedge clk);
        check("nt_done", 32'(dn[2]), 32'd1);
        check("nt_done_busy", 32'(bz[2]), 32'd0);
        check("nt_done_out", 32'(o2), 32'd0);
        st[2] = 1'b0;
        repeat (6) @(negedge clk);
        check("nt_done_clr", 32'(dn[2]), 32'd0);
        st[2] = 1'b1;
        fp_recv(2, 3, 1'b0, v, c, ok);
        check("nt_restart_ok", 32'(ok), 32'd1);
        check("nt_restart_val", 32'(v), 32'd0);

        // Asynchronous reset while instance 0 sits in WAIT_ACK on token 16
        n = 0;
        while (!fp_valid(0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_busy", 32'(bz[0]), 32'd1);
        #2;
        rst = 1'b1;
        st  = 3'b000;
        #1;
        check("arst_out", 32'(o0), 32'd0);
        check("arst_cout", 32'(c0), 32'd0);
        check("arst_busy", 32'(bz[0]), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ak    = 3'b000;
        st[0] = 1'b1;
        fp_recv(0, 3, 1'b0, v, c, ok);
        check("post_rst_ok", 32'(ok), 32'd1);
        check("post_rst_val", 32'(v), 32'd0);
        check("post_rst_c", 32'(c), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
